// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_sb register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned NRD_DEF  = 2;
    localparam int unsigned REG_ZERO = 0;

    function automatic int unsigned regfile_aw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register write-pending (busy) tracking and sticky hazard error flag.
// REGFILE_BYPASS_EN: a register being written this cycle counts as not busy for issue.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREG = NREG_DEF,
    localparam int unsigned AW   = regfile_aw(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_iss_en,
    input  logic [AW-1:0]   i_iss_addr,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_addr,
    output logic [NREG-1:0] o_busy,
    output logic            o_err,
    output logic            o_iss_ready_c
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic            w_iss_zero;
    logic            w_wb_hit;
    logic            w_iss_ready;
    logic            w_iss_take;

    assign w_iss_zero = (i_iss_addr == AW'(REG_ZERO));
    assign w_wb_hit   = i_wb_en && (i_wb_addr != AW'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    assign w_iss_ready = w_iss_zero || !r_busy[i_iss_addr]
                         || (w_wb_hit && (i_wb_addr == i_iss_addr));
`else
    assign w_iss_ready = w_iss_zero || !r_busy[i_iss_addr];
`endif

    assign w_iss_take = i_iss_en && w_iss_ready && !w_iss_zero;

    // Writeback clears first so a same-cycle accepted issue to that register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        w_err_nxt  = r_err;
        if (w_wb_hit) begin
            w_busy_nxt[i_wb_addr] = 1'b0;
            if (!r_busy[i_wb_addr] && !(w_iss_take && (i_iss_addr == i_wb_addr))) begin
                w_err_nxt = 1'b1;
            end
        end
        if (w_iss_take) begin
            w_busy_nxt[i_iss_addr] = 1'b1;
        end
        if (i_iss_en && !w_iss_ready) begin
            w_err_nxt = 1'b1;
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign o_busy        = r_busy;
    assign o_err         = r_err;
    assign o_iss_ready_c = w_iss_ready;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with multi-port combinational reads and a write-pending scoreboard.
// REGFILE_BYPASS_EN: forwards same-cycle writeback data/busy-clear onto the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN = XLEN_DEF,
    parameter  int unsigned NREG = NREG_DEF,
    parameter  int unsigned NRD  = NRD_DEF,
    localparam int unsigned AW   = regfile_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic                err
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_busy;
    logic            w_wb_hit;
    logic            w_iss_ready;
    logic            w_err;

    assign w_wb_hit = wb_en && (wb_addr != AW'(REG_ZERO));

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .i_iss_en      (iss_en),
        .i_iss_addr    (iss_addr),
        .i_wb_en       (wb_en),
        .i_wb_addr     (wb_addr),
        .o_busy        (w_busy),
        .o_err         (w_err),
        .o_iss_ready_c (w_iss_ready)
    );

    // Register 0 is never written, so it holds its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_hit) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_arr;

        assign w_addr = rd_addr[k*AW +: AW];
        assign w_arr  = (w_addr == AW'(REG_ZERO)) ? '0 : r_regs[w_addr];

`ifdef REGFILE_BYPASS_EN
        logic w_fwd;
        assign w_fwd = w_wb_hit && (wb_addr == w_addr);
        assign rd_data[k*XLEN +: XLEN] = w_fwd ? wb_data : w_arr;
        assign rd_busy[k]              = !w_fwd && w_busy[w_addr];
`else
        assign rd_data[k*XLEN +: XLEN] = w_arr;
        assign rd_busy[k]              = w_busy[w_addr];
`endif
    end

    assign iss_ready = w_iss_ready;
    assign err       = w_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, bypass corner sequence, random vs. model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                err;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural registers, pending flags, sticky error.
    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];
    logic            m_err;

    typedef struct {
        logic            r;
        logic            ie;
        logic [AW-1:0]   ia;
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   a0;
        logic [AW-1:0]   a1;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic            b0;
        logic            b1;
        logic            rdy;
        logic            e;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ie, input int ia, input logic we,
                                input int wa, input logic [XLEN-1:0] wd, input int a0, input int a1,
                                input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                                input logic b0, input logic b1, input logic rdy, input logic e);
        vec_t v;
        v.r = r; v.ie = ie; v.ia = AW'(ia); v.we = we; v.wa = AW'(wa); v.wd = wd;
        v.a0 = AW'(a0); v.a1 = AW'(a1); v.d0 = d0; v.d1 = d1;
        v.b0 = b0; v.b1 = b1; v.rdy = rdy; v.e = e;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] m_rd_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_rd_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && wb_en && wb_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic m_ready();
        return (iss_addr == 0) || !m_rd_busy(iss_addr);
    endfunction

    task automatic model_next();
        logic rdy;
        logic acc;
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            rdy = m_ready();
            acc = iss_en && rdy && (iss_addr != 0);
            if (iss_en && !rdy) m_err = 1'b1;
            if (wb_en && wb_addr != 0) begin
                if (!m_busy[wb_addr] && !(acc && iss_addr == wb_addr)) m_err = 1'b1;
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (acc) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic ie, input logic [AW-1:0] ia, input logic we,
                         input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rst = r; iss_en = ie; iss_addr = ia; wb_en = we; wb_addr = wa; wb_data = wd;
        rd_addr = {a1, a0};
    endtask

    task automatic finish_cycle();
        model_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 1, 7, 32'h12345678, 0, 1, 32'h0, 32'h0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0, 32'h0000FFFF, 7, 7, 32'h12345678, 32'h12345678, 0, 0, 1, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0, 0, 7, 32'h0, 32'h12345678, 0, 0, 1, 1);
        tbl[3]  = mk(1, 0, 0, 1, 5, 32'h0000DEAD, 7, 0, 32'h12345678, 32'h0, 0, 0, 1, 1);
        tbl[4]  = mk(0, 1, 3, 0, 0, 32'h0, 5, 7, 32'h0, 32'h0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 3, 0, 0, 32'h0, 3, 5, 32'h0, 32'h0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 1, 3, 0, 0, 32'h0, 3, 3, 32'h0, 32'h0, 1, 1, 0, 0);
        tbl[7]  = mk(0, 0, 3, 0, 0, 32'h0, 3, 0, 32'h0, 32'h0, 1, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 1, 3, 32'h000000A5, 0, 1, 32'h0, 32'h0, 0, 0, 1, 1);
        tbl[9]  = mk(0, 0, 3, 0, 0, 32'h0, 3, 3, 32'h000000A5, 32'h000000A5, 0, 0, 1, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 1, 9, 32'h00000099, 0, 1, 32'h0, 32'h0, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 32'h0, 9, 9, 32'h00000099, 32'h00000099, 0, 0, 1, 1);
        tbl[13] = mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
        tbl[14] = mk(0, 1, 4, 1, 4, 32'h00000044, 0, 1, 32'h0, 32'h0, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 4, 0, 0, 32'h0, 4, 4, 32'h00000044, 32'h00000044, 1, 1, 0, 0);

        // Power-on reset.
        drive(1, 0, 0, 0, 0, '0, 0, 0);
        finish_cycle();
        finish_cycle();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].ie, tbl[i].ia, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a0, tbl[i].a1);
            @(negedge clk);
            chk($sformatf("vec%0d rd_data0", i), rd_data[0 +: XLEN], tbl[i].d0);
            chk($sformatf("vec%0d rd_data1", i), rd_data[XLEN +: XLEN], tbl[i].d1);
            chk($sformatf("vec%0d rd_busy0", i), XLEN'(rd_busy[0]), XLEN'(tbl[i].b0));
            chk($sformatf("vec%0d rd_busy1", i), XLEN'(rd_busy[1]), XLEN'(tbl[i].b1));
            chk($sformatf("vec%0d iss_ready", i), XLEN'(iss_ready), XLEN'(tbl[i].rdy));
            chk($sformatf("vec%0d err", i), XLEN'(err), XLEN'(tbl[i].e));
            finish_cycle();
        end

        // Same-cycle writeback and read of a pending register: bypass decides old vs new.
        drive(0, 0, 0, 1, 6, 32'h11, 0, 0);
        finish_cycle();
        drive(0, 1, 6, 0, 0, '0, 0, 0);
        finish_cycle();
        drive(0, 0, 6, 1, 6, 32'h55, 6, 6);
        @(negedge clk);
        chk("byp rd_data", rd_data[0 +: XLEN], BYP ? 32'h55 : 32'h11);
        chk("byp rd_busy", XLEN'(rd_busy[1]), BYP ? 32'h0 : 32'h1);
        chk("byp iss_ready", XLEN'(iss_ready), BYP ? 32'h1 : 32'h0);
        finish_cycle();
        drive(0, 0, 6, 0, 0, '0, 6, 0);
        @(negedge clk);
        chk("post rd_data", rd_data[0 +: XLEN], 32'h55);
        chk("post rd_busy", XLEN'(rd_busy[0]), 32'h0);
        chk("post iss_ready", XLEN'(iss_ready), 32'h1);
        chk("post err", XLEN'(err), 32'h1);
        finish_cycle();

        // Randomised traffic on a small address window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            @(negedge clk);
            for (int k = 0; k < int'(NRD); k++) begin
                chk($sformatf("rnd%0d rd_data%0d", n, k), rd_data[k*XLEN +: XLEN],
                    m_rd_data(rd_addr[k*AW +: AW]));
                chk($sformatf("rnd%0d rd_busy%0d", n, k), XLEN'(rd_busy[k]),
                    XLEN'(m_rd_busy(rd_addr[k*AW +: AW])));
            end
            chk($sformatf("rnd%0d iss_ready", n), XLEN'(iss_ready), XLEN'(m_ready()));
            chk($sformatf("rnd%0d err", n), XLEN'(err), XLEN'(m_err));
            finish_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
